instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage of the MIPS core; sits directly upstream of the instruction ROM.
//  Owns the PC, drives the ROM word address and absorbs the ROM's 1-cycle registered read.
//  Passes {instruction, PC, PC+4} to decode over a valid/ready handshake.
//  Full throughput of 1 instr/cycle; stalls from decode and branch/jump redirects are handled without loss.
// PARAMETERS
//  RESET_PC   32'h0000_0000   byte address fetched first after reset (word aligned)
// PORTS
//  CLK           in   1   clock; all state updates on posedge
//  RST           in   1   asynchronous reset, active-high
//  ROM_ADDR      out  32  word index to ROM = {2'b00, fetch_pc[31:2]}; ROM returns data one edge later
//  ROM_DATA      in   32  ROM CONTENTS; valid the cycle after the address was presented
//  REDIRECT      in   1   branch/jump taken; sampled on posedge
//  REDIRECT_PC   in   32  target byte address; bits [1:0] ignored (forced to 0)
//  IF_VALID      out  1   IF_INSTR/IF_PC/IF_PC_PLUS4 hold a valid instruction
//  ID_READY      in   1   decode accepts this cycle; transfer = IF_VALID & ID_READY
//  IF_INSTR      out  32  instruction word
//  IF_PC         out  32  byte address of IF_INSTR
//  IF_PC_PLUS4   out  32  IF_PC + 4, modulo 2^32
// BEHAVIOUR
//  State: fetch_pc (32); inflight_v (1) and inflight_pc (32) for the address presented last cycle;
//   2-entry queue of {instr, pc} with head pointer and count (0..2).
//  Reset (async, RST=1): fetch_pc=RESET_PC, inflight_v=0, count=0, head=0,
//   IF_VALID=0, IF_INSTR=0, IF_PC=0, IF_PC_PLUS4=4, ROM_ADDR=RESET_PC>>2.
//  pop   = IF_VALID & ID_READY.
//  issue = ~REDIRECT & (count + inflight_v - pop < 2).
//  Each posedge, when REDIRECT=0:
//   - if issue: inflight_v<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps at 2^32).
//   - else: inflight_v<=0 and fetch_pc holds. The ROM re-reads the same address; that data is discarded.
//   - if inflight_v: push {ROM_DATA, inflight_pc} into the queue.
//   - if pop: advance head. Push and pop in the same edge are legal; count is unchanged.
//  Overflow cannot occur by construction; an assertion checks that count never exceeds 2.
//  Outputs are driven from the queue head; IF_VALID = (count != 0). Outputs are stable while IF_VALID & ~ID_READY.
//  REDIRECT=1 at posedge has priority over issue, push and pop:
//   fetch_pc<={REDIRECT_PC[31:2],2'b00}, inflight_v<=0, count<=0, head<=0.
//   IF_VALID is 0 for two cycles; the target instruction appears on the 2nd edge after the redirect edge.
//   A pop concurrent with REDIRECT still counts as a transfer for decode; decode is responsible for squashing it.
//  Latency: first edge after RST release issues RESET_PC; IF_VALID=1 after the 2nd edge.
//  Steady state with ID_READY=1: count=1 and inflight_v=1 every cycle, one instruction per cycle.
//  ID_READY=0 held: the queue fills to 2 within 2 edges, then issue=0 and fetch_pc freezes.
//   On ID_READY=1, the first post-stall instruction is presented the same cycle with no bubble.
//  RST mid-operation: all in-flight and queued instructions are dropped immediately; restart from RESET_PC.
// STRUCTURE
//  Shared package mips_defs: RESET_PC default, WORD_BYTES=4, PC_WIDTH=32, fetch bundle field widths.
//  Sub-module fetch_queue: 2-entry {instr, pc} FIFO with push/pop/flush, count, head outputs.
//  instr_fetch holds the PC/issue logic, the inflight register, the ROM address and the PC+4 adder.
// TESTING (bench pairs the block with the instruction ROM, loaded with ROM[i]=32'hA000_0000+i)
//  Reset/boot: RST 1->0, ID_READY=1 -> IF_VALID rises after the 2nd edge;
//   IF_INSTR=A0000000, IF_PC=0, IF_PC_PLUS4=4, then A0000001 at PC=4 on the next cycle.
//  Stall: ID_READY=0 for 5 cycles from PC=8 -> IF_INSTR stays A0000002, ROM_ADDR frozen at 4;
//   release -> A0000002, A0000003, A0000004 on consecutive cycles, no gap or duplicate.
//  Redirect: REDIRECT=1, REDIRECT_PC=32'h40 while streaming -> IF_VALID=0 for 2 cycles,
//   then A0000010 at PC=0x40; no instruction from the old path appears after the redirect edge.
//  Redirect during stall with a full queue: REDIRECT_PC=32'h23 -> both queued entries dropped; next output PC=0x20, A0000008.
//  Async reset mid-stream: RST pulsed between edges -> IF_VALID=0 and ROM_ADDR=0 immediately; reboot matches the boot test.
//  Random ID_READY (50%) over 200 cycles -> accepted PCs strictly sequential by +4; IF_INSTR low bits = PC>>2.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared MIPS fetch definitions: address widths, the boot PC and the
// {instr, pc} bundle carried from fetch to decode.
package mips_defs;

   localparam int PC_WIDTH    = 32;
   localparam int INSTR_WIDTH = 32;
   localparam int WORD_BYTES  = 4;
   localparam int QUEUE_DEPTH = 2;

   localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [INSTR_WIDTH-1:0] instr;
      logic [PC_WIDTH-1:0]    pc;
   } fetch_entry_t;

endpackage : mips_defs

// File: rtl/fetch_queue.sv
// Two-entry {instr, pc} FIFO that absorbs ROM data while decode stalls.
// Flush empties it in one edge; push and pop on the same edge keep the count.
module fetch_queue
   import mips_defs::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   input  logic         flush,
   output fetch_entry_t head_entry,
   output logic [1:0]   count,
   output logic         head
);

   fetch_entry_t entries [QUEUE_DEPTH];
   logic         tail;

   // With at most two entries the free slot is the head slot when empty
   // and the other slot when one entry is held.
   assign tail       = head ^ count[0];
   assign head_entry = entries[head];

   // Queue storage, head pointer and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         head  <= 1'b0;
         // NOTE: the two entries are reset because the head entry drives
         // the decode outputs directly and must read as zero out of reset.
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else if (flush) begin
         count <= '0;
         head  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples
         // the pre-edge values regardless of statement order.
         if (push) begin
            entries[tail] <= push_entry;
         end
         if (pop) begin
            head <= ~head;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // The issue throttle upstream guarantees the queue never overflows.
   a_count_bounded : assert property (@(posedge clk) disable iff (rst) count <= 2'd2);

endmodule : fetch_queue

// File: rtl/instr_fetch.sv
// MIPS fetch stage: owns the PC, addresses the registered instruction ROM,
// tracks the one read in flight and hands {instr, pc, pc+4} to decode.
module instr_fetch
   import mips_defs::*;
#(
   parameter logic [PC_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                   CLK,
   input  logic                   RST,
   output logic [PC_WIDTH-1:0]    ROM_ADDR,
   input  logic [INSTR_WIDTH-1:0] ROM_DATA,
   input  logic                   REDIRECT,
   input  logic [PC_WIDTH-1:0]    REDIRECT_PC,
   output logic                   IF_VALID,
   input  logic                   ID_READY,
   output logic [INSTR_WIDTH-1:0] IF_INSTR,
   output logic [PC_WIDTH-1:0]    IF_PC,
   output logic [PC_WIDTH-1:0]    IF_PC_PLUS4
);

   logic [PC_WIDTH-1:0] fetch_pc;
   logic [PC_WIDTH-1:0] inflight_pc;
   logic                inflight_v;

   logic                pop;
   logic                issue;
   logic [2:0]          occupancy;
   logic [1:0]          count;
   fetch_entry_t        head_entry;
   fetch_entry_t        push_entry;

   logic                unused_head;
   logic                unused_redirect_bits;

   // Redirect targets are word aligned by dropping the byte offset.
   assign unused_redirect_bits = ^REDIRECT_PC[1:0];

   // Issue a new ROM read only if the queue can still hold it once the
   // read in flight lands and any pop this edge has been taken out.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a value unassigned and infers a latch.
      pop       = 1'b0;
      occupancy = '0;
      issue     = 1'b0;
      pop       = IF_VALID & ID_READY;
      occupancy = {1'b0, count} + {2'b00, inflight_v} - {2'b00, pop};
      issue     = ~REDIRECT & (occupancy < 3'd2);
   end

   // PC and in-flight read tracking; a redirect overrides everything.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         fetch_pc    <= RESET_PC;
         inflight_v  <= 1'b0;
         inflight_pc <= '0;
      end else if (REDIRECT) begin
         fetch_pc    <= {REDIRECT_PC[PC_WIDTH-1:2], 2'b00};
         inflight_v  <= 1'b0;
      end else if (issue) begin
         fetch_pc    <= fetch_pc + PC_WIDTH'(WORD_BYTES);
         inflight_v  <= 1'b1;
         inflight_pc <= fetch_pc;
      end else begin
         inflight_v  <= 1'b0;
      end
   end

   assign push_entry = '{instr: ROM_DATA, pc: inflight_pc};

   fetch_queue u_queue (
      .clk        (CLK),
      .rst        (RST),
      .push       (inflight_v & ~REDIRECT),
      .push_entry (push_entry),
      .pop        (pop & ~REDIRECT),
      .flush      (REDIRECT),
      .head_entry (head_entry),
      .count      (count),
      .head       (unused_head)
   );

   assign ROM_ADDR    = {2'b00, fetch_pc[PC_WIDTH-1:2]};
   assign IF_VALID    = (count != 2'd0);
   assign IF_INSTR    = head_entry.instr;
   assign IF_PC       = head_entry.pc;
   assign IF_PC_PLUS4 = head_entry.pc + PC_WIDTH'(WORD_BYTES);

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch paired with a registered ROM model
// holding ROM[i] = 32'hA000_0000 + i.
module tb_instr_fetch;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] ROM_ADDR;
   logic [31:0] ROM_DATA;
   logic        REDIRECT = 1'b0;
   logic [31:0] REDIRECT_PC = '0;
   logic        IF_VALID;
   logic        ID_READY = 1'b1;
   logic [31:0] IF_INSTR;
   logic [31:0] IF_PC;
   logic [31:0] IF_PC_PLUS4;

   int n_checks = 0;
   int n_errors = 0;

   instr_fetch dut (
      .CLK         (CLK),
      .RST         (RST),
      .ROM_ADDR    (ROM_ADDR),
      .ROM_DATA    (ROM_DATA),
      .REDIRECT    (REDIRECT),
      .REDIRECT_PC (REDIRECT_PC),
      .IF_VALID    (IF_VALID),
      .ID_READY    (ID_READY),
      .IF_INSTR    (IF_INSTR),
      .IF_PC       (IF_PC),
      .IF_PC_PLUS4 (IF_PC_PLUS4)
   );

   always #5 CLK = ~CLK;

   // Registered instruction ROM: data for an address appears one edge later.
   always @(posedge CLK) ROM_DATA <= 32'hA000_0000 + ROM_ADDR;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge and sample just after it.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic expect_instr(input string tag, input logic [31:0] pc);
      check({tag, "_valid"}, IF_VALID, 1'b1);
      check({tag, "_pc"},    IF_PC,    pc);
      check({tag, "_instr"}, IF_INSTR, 32'hA000_0000 + (pc >> 2));
      check({tag, "_pc4"},   IF_PC_PLUS4, pc + 32'd4);
   endtask

   task automatic boot_sequence(input string tag);
      tick();
      check({tag, "_edge1_valid"}, IF_VALID, 1'b0);
      tick();
      expect_instr({tag, "_first"}, 32'h0);
      tick();
      expect_instr({tag, "_second"}, 32'h4);
   endtask

   logic [31:0] exp_pc;
   int          accepted;

   initial begin
      // Reset state.
      repeat (2) @(posedge CLK);
      #1;
      check("rst_valid", IF_VALID,    1'b0);
      check("rst_instr", IF_INSTR,    32'h0);
      check("rst_pc",    IF_PC,       32'h0);
      check("rst_pc4",   IF_PC_PLUS4, 32'h4);
      check("rst_addr",  ROM_ADDR,    32'h0);
      RST = 1'b0;

      boot_sequence("boot");

      // Stall with PC=8 at the head.
      tick();
      expect_instr("pre_stall", 32'h8);
      ID_READY = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_instr("stall", 32'h8);
         check("stall_addr", ROM_ADDR, 32'h4);
      end
      ID_READY = 1'b1;
      expect_instr("release0", 32'h8);
      tick();
      expect_instr("release1", 32'hC);
      tick();
      expect_instr("release2", 32'h10);

      // Redirect while streaming.
      REDIRECT    = 1'b1;
      REDIRECT_PC = 32'h40;
      tick();
      REDIRECT = 1'b0;
      check("redir_bubble1", IF_VALID, 1'b0);
      tick();
      check("redir_bubble2", IF_VALID, 1'b0);
      tick();
      expect_instr("redir_target", 32'h40);
      tick();
      expect_instr("redir_next", 32'h44);

      // Redirect with a full queue during a stall.
      ID_READY = 1'b0;
      tick();
      tick();
      expect_instr("full_hold", 32'h44);
      REDIRECT    = 1'b1;
      REDIRECT_PC = 32'h23;
      tick();
      REDIRECT = 1'b0;
      ID_READY = 1'b1;
      check("full_redir_bubble1", IF_VALID, 1'b0);
      tick();
      check("full_redir_bubble2", IF_VALID, 1'b0);
      tick();
      expect_instr("full_redir_target", 32'h20);
      tick();
      expect_instr("full_redir_next", 32'h24);

      // Asynchronous reset between edges.
      #2;
      RST = 1'b1;
      #1;
      check("async_rst_valid", IF_VALID, 1'b0);
      check("async_rst_addr",  ROM_ADDR, 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      boot_sequence("reboot");

      // Random decode back-pressure; PC 4 is at the head, not yet taken.
      exp_pc   = 32'h4;
      accepted = 0;
      for (int i = 0; i < 200; i++) begin
         ID_READY = 1'($urandom_range(0, 1));
         if (IF_VALID && ID_READY) begin
            check("rand_pc",    IF_PC,    exp_pc);
            check("rand_instr", IF_INSTR, 32'hA000_0000 + (exp_pc >> 2));
            exp_pc = exp_pc + 32'd4;
            accepted++;
         end
         tick();
      end
      check("rand_accepts", 32'(accepted >= 40), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_instr_fetch
